scoreboard_unit: RTL and testbench

- Parametrised successor to the fixed two-port dependency unit.
- Tracks in-flight register writes with per-register latency countdowns, forwards write-back data to N read ports, and raises a single stall to the fetch/read stages.
- Supports a configurable multi-cycle data-memory load latency and write-after-write ordering.
- Sits between the read stage, the register file and the write-back stage of the core.

---
 rtl/scoreboard_unit.sv | 130 +++++++++++++
 tb/tb_scoreboard_unit.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/scoreboard_unit.sv
// Register scoreboard: per-register write latency countdowns, write-back forwarding and a read-stage stall.
// Optional stall_count performance counter is enabled by defining SCOREBOARD_PERF_EN.
module scoreboard_unit #(
    parameter int GPR_COUNT    = 8,
    parameter int GPR_SIZE     = 3,
    parameter int DATA_SIZE    = 32,
    parameter int READ_PORTS   = 2,
    parameter int ALU_LATENCY  = 1,
    parameter int LOAD_LATENCY = 2,
    parameter int CNT_SIZE     = 3
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            flush,
    input  logic                            issue_valid,
    input  logic                            issue_writes,
    input  logic                            issue_is_load,
    input  logic [GPR_SIZE-1:0]             issue_dest,
    input  logic [READ_PORTS-1:0]           read_used,
    input  logic [READ_PORTS*GPR_SIZE-1:0]  read_address,
    input  logic [READ_PORTS*DATA_SIZE-1:0] rf_data,
    input  logic                            wb_valid,
    input  logic [GPR_SIZE-1:0]             wb_dest,
    input  logic [DATA_SIZE-1:0]            wb_data,
    output logic [READ_PORTS*DATA_SIZE-1:0] read_data,
    output logic [GPR_COUNT-1:0]            busy_mask,
    output logic                            stall
`ifdef SCOREBOARD_PERF_EN
    ,
    output logic [15:0]                     stall_count
`endif
);

    logic [CNT_SIZE-1:0] cnt_q [GPR_COUNT];
    logic [CNT_SIZE-1:0] cnt_d [GPR_COUNT];
    logic [GPR_SIZE-1:0] port_addr [READ_PORTS];
    logic [CNT_SIZE-1:0] new_lat;
    logic [READ_PORTS-1:0] src_hazard;
    logic waw_hazard;
    logic accept;

    always_comb begin
        for (int unsigned p = 0; p < READ_PORTS; p++) begin
            port_addr[p] = read_address[p*GPR_SIZE +: GPR_SIZE];
        end
    end

    always_comb begin
        new_lat = issue_is_load ? CNT_SIZE'(LOAD_LATENCY) : CNT_SIZE'(ALU_LATENCY);
    end

    // A write-back in the current cycle both forwards the value and masks the pending hazard.
    always_comb begin
        read_data  = rf_data;
        src_hazard = '0;
        for (int unsigned p = 0; p < READ_PORTS; p++) begin
            if (wb_valid && (wb_dest == port_addr[p]) && (port_addr[p] != '0)) begin
                read_data[p*DATA_SIZE +: DATA_SIZE] = wb_data;
            end
            src_hazard[p] = read_used[p] && (port_addr[p] != '0) &&
                            (cnt_q[port_addr[p]] != '0) &&
                            !(wb_valid && (wb_dest == port_addr[p]));
        end
    end

    always_comb begin
        waw_hazard = issue_valid && issue_writes && (issue_dest != '0) &&
                     (cnt_q[issue_dest] > new_lat);
        stall      = issue_valid && ((|src_hazard) || waw_hazard);
        accept     = issue_valid && !stall;
    end

    always_comb begin
        for (int unsigned r = 0; r < GPR_COUNT; r++) begin
            busy_mask[r] = (cnt_q[r] != '0);
        end
    end

    // The issue cycle is the first cycle of the latency, so the loaded count already
    // includes that cycle's decrement: a load at T is busy through T+LOAD_LATENCY-1.
    always_comb begin
        for (int unsigned r = 0; r < GPR_COUNT; r++) begin
            cnt_d[r] = cnt_q[r];
            if (r == 0) begin
                cnt_d[r] = '0;
            end else if (flush) begin
                cnt_d[r] = '0;
            end else if (accept && issue_writes && (issue_dest == GPR_SIZE'(r))) begin
                cnt_d[r] = new_lat - CNT_SIZE'(1);
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - CNT_SIZE'(1);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned r = 0; r < GPR_COUNT; r++) begin
                cnt_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < GPR_COUNT; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
        end
    end

`ifdef SCOREBOARD_PERF_EN
    logic [15:0] stall_count_q;
    logic [15:0] stall_count_d;

    always_comb begin
        stall_count_d = stall_count_q;
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_count_q <= '0;
        end else begin
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_scoreboard_unit.sv
// Directed bench for scoreboard_unit: one instance at default latencies, one with LOAD_LATENCY=3.
// Perf-counter checks are compiled in when SCOREBOARD_PERF_EN is defined.
module tb_scoreboard_unit;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        issue_valid;
    logic        issue_writes;
    logic        issue_is_load;
    logic [2:0]  issue_dest;
    logic [1:0]  read_used;
    logic [5:0]  read_address;
    logic [63:0] rf_data;
    logic        wb_valid;
    logic [2:0]  wb_dest;
    logic [31:0] wb_data;

    logic [63:0] rd, rd3;
    logic [7:0]  bm, bm3;
    logic        st, st3;
`ifdef SCOREBOARD_PERF_EN
    logic [15:0] sc, sc3;
`endif

    int n_cmp = 0;
    int n_err = 0;

    scoreboard_unit dut (
        .clock(clock), .reset(reset), .flush(flush),
        .issue_valid(issue_valid), .issue_writes(issue_writes),
        .issue_is_load(issue_is_load), .issue_dest(issue_dest),
        .read_used(read_used), .read_address(read_address), .rf_data(rf_data),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
        .read_data(rd), .busy_mask(bm), .stall(st)
`ifdef SCOREBOARD_PERF_EN
        , .stall_count(sc)
`endif
    );

    scoreboard_unit #(.LOAD_LATENCY(3)) dut3 (
        .clock(clock), .reset(reset), .flush(flush),
        .issue_valid(issue_valid), .issue_writes(issue_writes),
        .issue_is_load(issue_is_load), .issue_dest(issue_dest),
        .read_used(read_used), .read_address(read_address), .rf_data(rf_data),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
        .read_data(rd3), .busy_mask(bm3), .stall(st3)
`ifdef SCOREBOARD_PERF_EN
        , .stall_count(sc3)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        flush         = 1'b0;
        issue_valid   = 1'b0;
        issue_writes  = 1'b0;
        issue_is_load = 1'b0;
        issue_dest    = 3'd0;
        read_used     = 2'b00;
        read_address  = 6'd0;
        wb_valid      = 1'b0;
        wb_dest       = 3'd0;
        wb_data       = 32'd0;
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic issue_wr(input logic is_load, input logic [2:0] dest);
        idle();
        issue_valid   = 1'b1;
        issue_writes  = 1'b1;
        issue_is_load = is_load;
        issue_dest    = dest;
    endtask

    task automatic issue_dep(input logic [1:0] used, input logic [2:0] a1, input logic [2:0] a0);
        idle();
        issue_valid  = 1'b1;
        read_used    = used;
        read_address = {a1, a0};
    endtask

`ifdef SCOREBOARD_PERF_EN
    task automatic stall_pair();
        issue_wr(1'b1, 3'd3);
        cyc();
        issue_dep(2'b01, 3'd0, 3'd3);
        cyc();
        idle();
    endtask
`endif

    initial begin
        idle();
        rf_data = 64'h1111_2222_3333_4444;
        reset   = 1'b0;

        // Reset held with a busy-looking request
        issue_dep(2'b11, 3'd3, 3'd3);
        #3;
        check_eq("rst_busy", 64'(bm), 64'h00);
        check_eq("rst_stall", 64'(st), 64'h0);
        check_eq("rst_rdata", rd, 64'h1111_2222_3333_4444);
        idle();
        cyc();
        reset = 1'b1;

        // Reset asserted mid-operation clears pending state asynchronously
        issue_wr(1'b1, 3'd3);
        cyc();
        issue_dep(2'b01, 3'd0, 3'd3);
        #1;
        check_eq("mid_stall_pre", 64'(st3), 64'h1);
        check_eq("mid_busy_pre", 64'(bm3), 64'h08);
        reset = 1'b0;
        #1;
        check_eq("mid_stall_rst", 64'(st3), 64'h0);
        check_eq("mid_busy_rst", 64'(bm3), 64'h00);
        reset = 1'b1;
        idle();
        cyc();

        // Load r3 then dependent: one stall cycle, then forwarded write-back
        issue_wr(1'b1, 3'd3);
        #1;
        check_eq("ld_issue_stall", 64'(st), 64'h0);
        cyc();
        issue_dep(2'b01, 3'd0, 3'd3);
        rf_data = 64'hAAAA_AAAA_5555_5555;
        #1;
        check_eq("ld_dep_stall", 64'(st), 64'h1);
        check_eq("ld_dep_busy", 64'(bm), 64'h08);
        cyc();
        issue_dep(2'b01, 3'd0, 3'd3);
        wb_valid = 1'b1;
        wb_dest  = 3'd3;
        wb_data  = 32'hDEADBEEF;
        #1;
        check_eq("ld_wb_stall", 64'(st), 64'h0);
        check_eq("ld_wb_fwd", rd, 64'hAAAA_AAAA_DEAD_BEEF);
        cyc();
        idle();
        #1;
        check_eq("ld_done_busy", 64'(bm), 64'h00);

        // ALU r5 then dependent with same-cycle write-back; r0 never forwards or stalls
        issue_wr(1'b0, 3'd5);
        cyc();
        issue_dep(2'b11, 3'd0, 3'd5);
        rf_data  = 64'hCCCC_0000_DDDD_0000;
        wb_valid = 1'b1;
        wb_dest  = 3'd5;
        wb_data  = 32'h0000_0042;
        #1;
        check_eq("alu_stall", 64'(st), 64'h0);
        check_eq("alu_fwd", rd, 64'hCCCC_0000_0000_0042);
        issue_dep(2'b11, 3'd0, 3'd0);
        wb_valid = 1'b1;
        wb_dest  = 3'd0;
        wb_data  = 32'hFFFF_FFFF;
        #1;
        check_eq("r0_rdata", rd, 64'hCCCC_0000_DDDD_0000);
        check_eq("r0_stall", 64'(st), 64'h0);
        cyc();
        idle();

        // WAW: load r2 then ALU r2
        issue_wr(1'b1, 3'd2);
        cyc();
        issue_wr(1'b0, 3'd2);
        #1;
        check_eq("waw_ll2_stall", 64'(st), 64'h0);
        check_eq("waw_ll3_stall1", 64'(st3), 64'h1);
        cyc();
        #1;
        check_eq("waw_ll3_stall2", 64'(st3), 64'h0);
        cyc();
        idle();
        #1;
        check_eq("waw_ll3_busy", 64'(bm3), 64'h00);

        // Pending loads then flush concurrent with a new load
        issue_wr(1'b1, 3'd1);
        cyc();
        issue_wr(1'b1, 3'd4);
        cyc();
        issue_wr(1'b1, 3'd6);
        flush = 1'b1;
        #1;
        check_eq("fl_busy3_pre", 64'(bm3), 64'h12);
        check_eq("fl_busy_pre", 64'(bm), 64'h10);
        cyc();
        issue_dep(2'b11, 3'd4, 3'd6);
        #1;
        check_eq("fl_busy3_post", 64'(bm3), 64'h00);
        check_eq("fl_stall3_post", 64'(st3), 64'h0);
        check_eq("fl_busy_post", 64'(bm), 64'h00);
        cyc();

        // Destination r0 is never tracked
        issue_wr(1'b1, 3'd0);
        cyc();
        idle();
        #1;
        check_eq("dest0_busy", 64'({bm3, bm}), 64'h0000);

`ifdef SCOREBOARD_PERF_EN
        reset = 1'b0;
        #1;
        reset = 1'b1;
        check_eq("perf_rst", 64'(sc), 64'h0);
        for (int i = 0; i < 5; i++) stall_pair();
        #1;
        check_eq("perf_five", 64'(sc), 64'h5);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        #1;
        check_eq("perf_flush", 64'(sc), 64'h5);
        force dut.stall_count_q = 16'hFFFE;
        #1;
        release dut.stall_count_q;
        for (int i = 0; i < 3; i++) stall_pair();
        #1;
        check_eq("perf_sat", 64'(sc), 64'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
